fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, a single-entry
// instruction buffer, and redirect handling that drops responses already in flight.
module fetch_ctrl #(
    parameter int                     PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = 32'hBFC00000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_target_i,
    output logic                imem_req_o,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic                imem_ready_i,
    input  logic                imem_rvalid_i,
    input  logic [31:0]         imem_rdata_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                instr_valid_o,
    output logic [31:0]         instr_o,
    output logic [PC_WIDTH-1:0] instr_pc_o,
    output logic                flush_o
);

    // state  | meaning
    // S_BOOT | one idle cycle after reset release
    // S_REQ  | presenting a request at pc_q
    // S_WAIT | request accepted, waiting for read data
    // S_HOLD | instruction buffered, waiting for downstream to take it
    typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  discard_q, discard_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [31:0]           instr_q, instr_d;
    logic [PC_WIDTH-1:0]   instr_pc_q, instr_pc_d;
    logic                  flush_q, flush_d;

    logic                  unused_tgt_bits;
    assign unused_tgt_bits = ^redirect_target_i[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_VECTOR;
            discard_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            discard_q     <= discard_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            flush_q       <= flush_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        discard_d     = discard_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        flush_d       = redirect_i;

        if (redirect_i) begin
            // Redirect beats stall and capture; an accepted or pending request
            // keeps us in WAIT so its stale response can be swallowed.
            pc_d          = {redirect_target_i[PC_WIDTH-1:2], 2'b00};
            instr_valid_d = 1'b0;
            state_d       = S_REQ;
            discard_d     = 1'b0;
            if (state_q == S_REQ && imem_ready_i) begin
                discard_d = 1'b1;
                state_d   = S_WAIT;
            end else if (state_q == S_WAIT && !imem_rvalid_i) begin
                discard_d = 1'b1;
                state_d   = S_WAIT;
            end
        end else begin
            case (state_q)
                S_BOOT: state_d = S_REQ;
                S_REQ: begin
                    if (imem_ready_i) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else begin
                            instr_d       = imem_rdata_i;
                            instr_pc_d    = pc_q;
                            instr_valid_d = 1'b1;
                            pc_d          = pc_q + PC_WIDTH'(4);
                            state_d       = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        instr_valid_d = 1'b0;
                        state_d       = S_REQ;
                    end
                end
                default: state_d = S_BOOT;
            endcase
        end
    end

    assign imem_req_o    = (state_q == S_REQ);
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign flush_o       = flush_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run, all checked
// against a transaction-level model (outstanding / stale / buffer occupancy).
module tb_fetch_ctrl;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        flush_o;

    fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_ready_i      (imem_ready_i),
        .imem_rvalid_i     (imem_rvalid_i),
        .imem_rdata_i      (imem_rdata_i),
        .pc_o              (pc_o),
        .instr_valid_o     (instr_valid_o),
        .instr_o           (instr_o),
        .instr_pc_o        (instr_pc_o),
        .flush_o           (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: fetch viewed as "is a request outstanding, is it stale,
    // is the one-entry buffer full", plus the PC and the flush pulse.
    logic        m_boot, m_out, m_stale, m_bv, m_flush;
    logic [31:0] m_pc, m_buf, m_bpc;

    function automatic logic m_req();
        return !m_boot && !m_out && !m_bv;
    endfunction

    function automatic logic [130:0] exp_vec();
        return {m_req(), m_pc, m_pc, m_bv, m_buf, m_bpc, m_flush};
    endfunction

    logic [130:0] dut_vec;
    assign dut_vec = {imem_req_o, imem_addr_o, pc_o, instr_valid_o, instr_o, instr_pc_o, flush_o};

    task automatic model_reset();
        m_boot = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_bv = 1'b0; m_flush = 1'b0;
        m_pc = RV; m_buf = '0; m_bpc = '0;
    endtask

    task automatic model_step();
        logic req;
        req = m_req();
        if (redirect_i) begin
            m_pc    = redirect_target_i & 32'hFFFF_FFFC;
            m_bv    = 1'b0;
            m_boot  = 1'b0;
            m_flush = 1'b1;
            if (req && imem_ready_i) begin
                m_out = 1'b1; m_stale = 1'b1;
            end else if (m_out) begin
                if (imem_rvalid_i) begin
                    m_out = 1'b0; m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end
        end else begin
            m_flush = 1'b0;
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (req && imem_ready_i) begin
                m_out = 1'b1; m_stale = 1'b0;
            end else if (m_out && imem_rvalid_i) begin
                if (!m_stale) begin
                    m_bv  = 1'b1;
                    m_buf = imem_rdata_i;
                    m_bpc = m_pc;
                    m_pc  = m_pc + 32'd4;
                end
                m_out = 1'b0; m_stale = 1'b0;
            end else if (m_bv && !stall_i) begin
                m_bv = 1'b0;
            end
        end
    endtask

    // Called at a falling edge; applies inputs for one rising edge, returns at the next falling edge.
    task automatic drive(input logic st, input logic rd, input logic [31:0] tgt,
                         input logic rdy, input logic rv, input logic [31:0] dat);
        stall_i = st; redirect_i = rd; redirect_target_i = tgt;
        imem_ready_i = rdy; imem_rvalid_i = rv; imem_rdata_i = dat;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        stall_i = 0; redirect_i = 0; redirect_target_i = '0;
        imem_ready_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (dut_vec !== {1'b0, RV, RV, 1'b0, 32'h0, 32'h0, 1'b0})
            $display("FAIL reset_values: got %h expected %h", dut_vec, {1'b0, RV, RV, 1'b0, 32'h0, 32'h0, 1'b0});
        else n_pass++;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, RV})
            $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, RV);
        else n_pass++;
    endtask

    task automatic test_first_fetch();
        drive(0, 0, 0, 1, 0, 0);
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL accept: got %h expected %h", dut_vec, exp_vec());
        else n_pass++;
        drive(0, 0, 0, 0, 1, 32'h00000013);
        n_checks++;
        if ({instr_valid_o, instr_o, instr_pc_o, pc_o, imem_req_o} !== {1'b1, 32'h13, RV, RV + 32'd4, 1'b0})
            $display("FAIL first_capture: got v=%b i=%h ipc=%h pc=%h req=%b", instr_valid_o, instr_o, instr_pc_o, pc_o, imem_req_o);
        else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 1, 1, 32'hFFFF_FFFF);
            n_checks++;
            if ({instr_valid_o, instr_o, instr_pc_o, pc_o, imem_req_o} !== {1'b1, 32'h13, RV, RV + 32'd4, 1'b0})
                $display("FAIL stall_hold%0d: got v=%b i=%h ipc=%h pc=%h req=%b", i, instr_valid_o, instr_o, instr_pc_o, pc_o, imem_req_o);
            else n_pass++;
        end
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({instr_valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, RV + 32'd4})
            $display("FAIL stall_release: got v=%b req=%b addr=%h expected v=0 req=1 addr=%h", instr_valid_o, imem_req_o, imem_addr_o, RV + 32'd4);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 1, 32'h80000002, 0, 0, 0);
        n_checks++;
        if ({flush_o, pc_o, imem_req_o} !== {1'b1, 32'h80000000, 1'b0})
            $display("FAIL redir_wait: got flush=%b pc=%h req=%b expected 1 80000000 0", flush_o, pc_o, imem_req_o);
        else n_pass++;
        drive(0, 0, 0, 0, 1, 32'hDEADBEEF);
        n_checks++;
        if ({flush_o, instr_valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b0, 1'b1, 32'h80000000})
            $display("FAIL redir_wait_drop: got flush=%b v=%b req=%b addr=%h", flush_o, instr_valid_o, imem_req_o, imem_addr_o);
        else n_pass++;
    endtask

    task automatic test_redirect_ready();
        drive(0, 1, 32'h90000010, 1, 0, 0);
        n_checks++;
        if ({flush_o, pc_o, imem_req_o} !== {1'b1, 32'h90000010, 1'b0})
            $display("FAIL redir_ready: got flush=%b pc=%h req=%b expected 1 90000010 0", flush_o, pc_o, imem_req_o);
        else n_pass++;
        drive(0, 0, 0, 0, 1, 32'hCAFEF00D);
        n_checks++;
        if ({flush_o, instr_valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b0, 1'b1, 32'h90000010})
            $display("FAIL redir_ready_drop: got flush=%b v=%b req=%b addr=%h", flush_o, instr_valid_o, imem_req_o, imem_addr_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] tg [3];
        tg[0] = 32'h00001000; tg[1] = 32'h00002007; tg[2] = 32'h0000300B;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, tg[i], 0, 0, 0);
            n_checks++;
            if ({flush_o, pc_o} !== {1'b1, tg[i] & 32'hFFFF_FFFC})
                $display("FAIL b2b_%0d: got flush=%b pc=%h expected 1 %h", i, flush_o, pc_o, tg[i] & 32'hFFFF_FFFC);
            else n_pass++;
        end
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({flush_o, pc_o, imem_req_o} !== {1'b0, 32'h00003008, 1'b1})
            $display("FAIL b2b_end: got flush=%b pc=%h req=%b expected 0 00003008 1", flush_o, pc_o, imem_req_o);
        else n_pass++;
    endtask

    task automatic test_wrap();
        drive(0, 1, 32'hFFFFFFFC, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h11111111);
        n_checks++;
        if ({instr_valid_o, instr_o, instr_pc_o, pc_o} !== {1'b1, 32'h11111111, 32'hFFFFFFFC, 32'h0})
            $display("FAIL wrap: got v=%b i=%h ipc=%h pc=%h expected 1 11111111 fffffffc 00000000", instr_valid_o, instr_o, instr_pc_o, pc_o);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_in_wait();
        drive(0, 0, 0, 1, 0, 0);
        #1 rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec !== {1'b0, RV, RV, 1'b0, 32'h0, 32'h0, 1'b0})
            $display("FAIL reset_in_wait: got %h expected %h", dut_vec, {1'b0, RV, RV, 1'b0, 32'h0, 32'h0, 1'b0});
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 1, 32'h0BADBAD0);
        n_checks++;
        if ({instr_valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, RV})
            $display("FAIL stale_boot: got v=%b req=%b addr=%h expected 0 1 %h", instr_valid_o, imem_req_o, imem_addr_o, RV);
        else n_pass++;
        drive(0, 0, 0, 0, 1, 32'h0BADBAD1);
        n_checks++;
        if ({instr_valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, RV})
            $display("FAIL stale_req: got v=%b req=%b addr=%h expected 0 1 %h", instr_valid_o, imem_req_o, imem_addr_o, RV);
        else n_pass++;
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h22222222);
        n_checks++;
        if ({instr_valid_o, instr_o, instr_pc_o, pc_o} !== {1'b1, 32'h22222222, RV, RV + 32'd4})
            $display("FAIL resume: got v=%b i=%h ipc=%h pc=%h", instr_valid_o, instr_o, instr_pc_o, pc_o);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                model_reset();
                @(negedge clk);
                rst = 1'b1;
            end
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, tgt,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom);
            n_checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_ready();
        test_back_to_back();
        test_wrap();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
